// File: rtl/free_list_multiport_pkg.sv
// Shared constants and types for the rename-stage physical register free list.
// Default configuration: 32 arch regs, 64 pregs, 32-entry list, 4 lanes.
package free_list_multiport_pkg;

  localparam int NUM_ARCH_REGS = 32;
  localparam int NUM_PHYS_REGS = 64;
  localparam int FL_DEPTH      = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int ALLOC_WIDTH   = 4;
  localparam int FREE_WIDTH    = 4;
  localparam int PREG_W        = $clog2(NUM_PHYS_REGS);
  localparam int FL_PTR_W      = $clog2(FL_DEPTH) + 1;

  // Physical register index.
  typedef logic [PREG_W-1:0] preg_t;

  // List pointer: index bits plus one wrap bit.
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

endpackage

// File: rtl/free_list_multiport_lane_compactor.sv
// Lane compactor: exclusive prefix popcount per lane plus total popcount.
// Ports: valid (lane mask) -> prefix (set lanes below i), total (popcount).
module lane_compactor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]            valid,
  output logic [WIDTH-1:0][CNT_W-1:0] prefix,
  output logic [CNT_W-1:0]            total
);
  import free_list_multiport_pkg::*;

  logic [CNT_W-1:0] acc;

  always_comb begin
    acc    = '0;
    prefix = '0;
    for (int i = 0; i < WIDTH; i++) begin
      prefix[i] = acc;
      acc       = acc + CNT_W'(valid[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/free_list_multiport.sv
// Multi-port physical register free list with speculative and committed heads.
// Ports: clock/reset (sync, active-high); alloc_valid/alloc_ready/alloc_preg
// allocate lanes; free_valid/free_preg return lanes; commit_valid retires
// allocations; flush restores spec head; free_count is registered occupancy.
module free_list_multiport #(
  parameter int NUM_ARCH_REGS =
    free_list_multiport_pkg::NUM_ARCH_REGS,
  parameter int NUM_PHYS_REGS =
    free_list_multiport_pkg::NUM_PHYS_REGS,
  parameter int ALLOC_WIDTH =
    free_list_multiport_pkg::ALLOC_WIDTH,
  parameter int FREE_WIDTH =
    free_list_multiport_pkg::FREE_WIDTH,
  parameter int PREG_W = $clog2(NUM_PHYS_REGS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [ALLOC_WIDTH-1:0]        alloc_valid,
  output logic                          alloc_ready,
  output logic [ALLOC_WIDTH*PREG_W-1:0] alloc_preg,
  input  logic [FREE_WIDTH-1:0]         free_valid,
  input  logic [FREE_WIDTH*PREG_W-1:0]  free_preg,
  input  logic [FREE_WIDTH-1:0]         commit_valid,
  input  logic                          flush,
  output logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS):0] free_count
);
  import free_list_multiport_pkg::*;

  localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int A_CW  = $clog2(ALLOC_WIDTH + 1);
  localparam int F_CW  = $clog2(FREE_WIDTH + 1);

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [PREG_W-1:0] phys_t;

  localparam ptr_t ALLOC_N = ptr_t'(ALLOC_WIDTH);
  localparam ptr_t FULL    = ptr_t'(DEPTH);

  phys_t entries [DEPTH];
  ptr_t  spec_head;
  ptr_t  commit_head;
  ptr_t  tail;

  ptr_t  count;
  ptr_t  spec_next;
  ptr_t  commit_next;
  ptr_t  tail_next;
  logic  do_alloc;

  logic [ALLOC_WIDTH-1:0][A_CW-1:0] a_pre;
  logic [A_CW-1:0]                  a_tot;
  logic [FREE_WIDTH-1:0][F_CW-1:0]  f_pre;
  logic [F_CW-1:0]                  f_tot;
  logic [FREE_WIDTH-1:0][F_CW-1:0]  c_pre;
  logic [F_CW-1:0]                  c_tot;

  lane_compactor #(.WIDTH(ALLOC_WIDTH)) u_alloc_cmp (
    .valid  (alloc_valid),
    .prefix (a_pre),
    .total  (a_tot)
  );

  lane_compactor #(.WIDTH(FREE_WIDTH)) u_free_cmp (
    .valid  (free_valid),
    .prefix (f_pre),
    .total  (f_tot)
  );

  lane_compactor #(.WIDTH(FREE_WIDTH)) u_commit_cmp (
    .valid  (commit_valid),
    .prefix (c_pre),
    .total  (c_tot)
  );

  // Occupancy from registered pointers only; same-cycle frees never
  // raise alloc_ready.
  assign count       = tail - spec_head;
  assign alloc_ready = (count >= ALLOC_N);
  assign do_alloc    = (|alloc_valid) & alloc_ready & ~flush;

  // Valid lanes read consecutive slots starting at spec_head.
  always_comb begin
    alloc_preg = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_preg[i*PREG_W +: PREG_W] =
        entries[IDX_W'(spec_head + ptr_t'(a_pre[i]))];
    end
  end

  // Flush rewinds to the committed head, including this cycle's commits.
  always_comb begin
    spec_next = spec_head;
    if (flush) begin
      spec_next = commit_head + ptr_t'(c_tot);
    end else if (do_alloc) begin
      spec_next = spec_head + ptr_t'(a_tot);
    end
  end

  assign commit_next = commit_head + ptr_t'(c_tot);
  assign tail_next   = tail + ptr_t'(f_tot);

  always_ff @(posedge clock) begin
    if (reset) begin
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= FULL;
      free_count  <= FULL;
      for (int k = 0; k < DEPTH; k++) begin
        entries[k] <= phys_t'(NUM_ARCH_REGS + k);
      end
    end else begin
      spec_head   <= spec_next;
      commit_head <= commit_next;
      tail        <= tail_next;
      free_count  <= tail_next - spec_next;
      for (int j = 0; j < FREE_WIDTH; j++) begin
        if (free_valid[j]) begin
          entries[IDX_W'(tail + ptr_t'(f_pre[j]))] <=
            free_preg[j*PREG_W +: PREG_W];
        end
      end
    end
  end

  // Protocol checks for the surrounding pipeline; not handled in logic.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (int'(count) + int'(f_tot) <= DEPTH)
        else $error("free list overflow: count=%0d frees=%0d",
                    count, f_tot);
      assert (int'(c_pre[FREE_WIDTH-1]) +
              int'(commit_valid[FREE_WIDTH-1]) <=
              int'(ptr_t'(spec_head - commit_head)))
        else $error("commit head passes spec head");
      for (int j = 0; j < FREE_WIDTH; j++) begin
        assert (!(free_valid[j] &&
                  free_preg[j*PREG_W +: PREG_W] == '0))
          else $error("preg 0 freed on lane %0d", j);
      end
    end
  end

endmodule

// File: tb/tb_free_list_multiport.sv
// Bench for free_list_multiport: directed steps plus random traffic
// checked against a queue-based model of free and in-flight pregs.
module tb_free_list_multiport;
  import free_list_multiport_pkg::*;

  localparam int AW = ALLOC_WIDTH;
  localparam int FW = FREE_WIDTH;
  localparam int PW = PREG_W;

  logic               clock = 1'b0;
  logic               reset;
  logic [AW-1:0]      alloc_valid;
  logic               alloc_ready;
  logic [AW*PW-1:0]   alloc_preg;
  logic [FW-1:0]      free_valid;
  logic [FW*PW-1:0]   free_preg;
  logic [FW-1:0]      commit_valid;
  logic               flush;
  logic [$clog2(FL_DEPTH):0] free_count;

  int n_chk  = 0;
  int n_fail = 0;

  // freeq: allocatable pregs in order; sq: allocated, not yet committed.
  int freeq[$];
  int sq[$];

  always #5 clock = ~clock;

  free_list_multiport dut (
    .clock        (clock),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_preg   (alloc_preg),
    .free_valid   (free_valid),
    .free_preg    (free_preg),
    .commit_valid (commit_valid),
    .flush        (flush),
    .free_count   (free_count)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(int i);
    return 32'(alloc_preg[i*PW +: PW]);
  endfunction

  task automatic idle();
    alloc_valid  = '0;
    free_valid   = '0;
    free_preg    = '0;
    commit_valid = '0;
    flush        = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    alloc_valid  = '1;
    free_valid   = '1;
    free_preg    = {FW{6'd9}};
    commit_valid = '1;
    flush        = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle();
    freeq.delete();
    sq.delete();
    for (int k = 0; k < FL_DEPTH; k++) freeq.push_back(NUM_ARCH_REGS + k);
    chk("reset_count", free_count, FL_DEPTH);
    chk("reset_ready", alloc_ready, 1);
    for (int i = 0; i < AW; i++) chk("reset_lane", lane(i), NUM_ARCH_REGS + i);
  endtask

  // Drive one cycle of inputs and check combinational outputs before the edge.
  task automatic drive(logic [AW-1:0] av, logic [FW-1:0] fv,
                       logic [FW*PW-1:0] fp, logic [FW-1:0] cv,
                       logic fl_i);
    int n;
    alloc_valid  = av;
    free_valid   = fv;
    free_preg    = fp;
    commit_valid = cv;
    flush        = fl_i;
    #4;
    chk("alloc_ready", alloc_ready, freeq.size() >= AW);
    if (freeq.size() >= AW) begin
      n = 0;
      for (int i = 0; i < AW; i++) begin
        if (av[i]) begin
          chk($sformatf("alloc_preg%0d", i), lane(i), freeq[n]);
          n++;
        end
      end
    end
  endtask

  // Clock edge, then advance the model and check registered state.
  task automatic tick();
    int c;
    int k;
    @(posedge clock);
    #1;
    c = $countones(commit_valid);
    k = $countones(alloc_valid);
    repeat (c) void'(sq.pop_front());
    if (flush) begin
      for (int i = sq.size() - 1; i >= 0; i--) freeq.push_front(sq[i]);
      sq.delete();
    end else if (k != 0 && freeq.size() >= AW) begin
      repeat (k) sq.push_back(freeq.pop_front());
    end
    for (int j = 0; j < FW; j++) begin
      if (free_valid[j]) freeq.push_back(int'(free_preg[j*PW +: PW]));
    end
    chk("free_count", free_count, freeq.size());
    chk("ready_next", alloc_ready, freeq.size() >= AW);
    idle();
  endtask

  initial begin
    logic [AW-1:0]    av;
    logic [FW-1:0]    fv;
    logic [FW-1:0]    cv;
    logic [FW*PW-1:0] fp;
    logic             fl_r;

    idle();

    // Full-width allocation from reset.
    do_reset();
    drive(4'b1111, '0, '0, '0, 1'b0);
    for (int i = 0; i < AW; i++) chk("t1_lane", lane(i), 32 + i);
    tick();
    chk("t1_count", free_count, 28);
    drive(4'b0001, '0, '0, '0, 1'b0);
    chk("t1_next_lane0", lane(0), 36);
    tick();

    // Sparse lanes compact onto consecutive entries.
    do_reset();
    drive(4'b1010, '0, '0, '0, 1'b0);
    chk("t2_lane1", lane(1), 32);
    chk("t2_lane3", lane(3), 33);
    tick();
    chk("t2_count", free_count, 30);

    // Ready threshold and ignored request.
    do_reset();
    repeat (7) begin
      drive(4'b1111, '0, '0, '0, 1'b0);
      tick();
    end
    chk("t3_count4", free_count, 4);
    chk("t3_ready4", alloc_ready, 1);
    drive(4'b0001, '0, '0, '0, 1'b0);
    tick();
    chk("t3_count3", free_count, 3);
    chk("t3_ready3", alloc_ready, 0);
    drive(4'b1111, '0, '0, '0, 1'b0);
    tick();
    chk("t3_ignored", free_count, 3);
    drive('0, 4'b0001, 24'd5, '0, 1'b0);
    tick();
    chk("t3_refill", free_count, 4);
    chk("t3_ready_again", alloc_ready, 1);

    // Flush with same-cycle commit.
    do_reset();
    drive(4'b1111, '0, '0, '0, 1'b0);
    tick();
    drive(4'b1111, '0, '0, '0, 1'b0);
    tick();
    drive('0, '0, '0, 4'b0011, 1'b1);
    tick();
    chk("t4_count", free_count, 30);
    drive(4'b0001, '0, '0, '0, 1'b0);
    chk("t4_lane0", lane(0), 34);
    tick();

    // Tail wraps into entries 0..3.
    do_reset();
    repeat (8) begin
      drive(4'b1111, '0, '0, '0, 1'b0);
      tick();
    end
    chk("t5_empty", free_count, 0);
    chk("t5_ready", alloc_ready, 0);
    drive('0, 4'b1111, {6'd43, 6'd42, 6'd41, 6'd40}, '0, 1'b0);
    tick();
    chk("t5_count", free_count, 4);
    drive(4'b1111, '0, '0, '0, 1'b0);
    for (int i = 0; i < AW; i++) chk("t5_lane", lane(i), 40 + i);
    tick();
    chk("t5_count0", free_count, 0);
    chk("t5_tail", dut.tail, 36);
    chk("t5_spec", dut.spec_head, 36);

    // Same-cycle alloc, free and commit.
    do_reset();
    repeat (7) begin
      drive(4'b1111, '0, '0, '0, 1'b0);
      tick();
    end
    drive(4'b1111, 4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, 4'b1111, 1'b0);
    tick();
    chk("t6_count", free_count, 4);
    chk("t6_ready", alloc_ready, 1);
    drive(4'b1111, '0, '0, '0, 1'b0);
    for (int i = 0; i < AW; i++) chk("t6_lane", lane(i), 10 + i);
    tick();

    // Random traffic against the model.
    do_reset();
    repeat (800) begin
      av   = AW'($urandom);
      fl_r = ($urandom_range(0, 15) == 0);
      cv   = FW'($urandom);
      while ($countones(cv) > sq.size()) cv = cv & (cv - 1'b1);
      fv   = FW'($urandom);
      while (freeq.size() + sq.size() + $countones(fv) > FL_DEPTH)
        fv = fv & (fv - 1'b1);
      fp = '0;
      for (int j = 0; j < FW; j++)
        fp[j*PW +: PW] = PW'($urandom_range(1, NUM_PHYS_REGS - 1));
      drive(av, fv, fp, cv, fl_r);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/free_list_multiport.md
Name: free_list_multiport

Overview:
- Parametrised physical-register free list for the rename stage.
- Circular buffer of free physical register indices with multi-lane allocate, multi-lane free, and a committed head pointer.
- Supports speculative allocation and single-cycle restore on pipeline flush.
- Rename allocates destination pregs; commit returns stale pregs and retires allocations.

Parameters:
- NUM_ARCH_REGS, 32, architectural registers; pregs 0..NUM_ARCH_REGS-1 are mapped at reset and never in the list initially.
- NUM_PHYS_REGS, 64, total physical registers. DEPTH = NUM_PHYS_REGS-NUM_ARCH_REGS; DEPTH must be a power of two.
- ALLOC_WIDTH, 4, allocate lanes per cycle.
- FREE_WIDTH, 4, free lanes per cycle; also the commit lane count.
- PREG_W, $clog2(NUM_PHYS_REGS), width of a physical register index.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- alloc_valid  in  ALLOC_WIDTH  per-lane allocate request; sparse lane patterns allowed.
- alloc_ready  out  1  all lanes may allocate this cycle.
- alloc_preg  out  ALLOC_WIDTH*PREG_W  allocated preg per lane.
- free_valid  in  FREE_WIDTH  per-lane free.
- free_preg  in  FREE_WIDTH*PREG_W  preg returned per lane.
- commit_valid  in  FREE_WIDTH  per-lane retirement of one earlier allocation.
- flush  in  1  discard all uncommitted allocations.
- free_count  out  $clog2(DEPTH)+1  registered occupancy.

Behaviour:
- State:
  - entries[DEPTH] of PREG_W bits.
  - spec_head, commit_head, tail pointers, each $clog2(DEPTH)+1 bits (extra wrap bit).
  - count = tail - spec_head; full when pointers are equal except the wrap bit.
- Reset:
  - entries[k] = NUM_ARCH_REGS+k.
  - spec_head = commit_head = 0; tail = DEPTH with wrap bit set, so the list is full.
  - free_count = DEPTH; alloc_ready = 1; alloc_preg lane i = NUM_ARCH_REGS+i.
  - Reset overrides flush, alloc, free and commit in the same cycle.
- alloc_ready = (count >= ALLOC_WIDTH). It is all-or-nothing and derived from registered state only; same-cycle frees do not raise it.
- Allocation is combinational from registered state:
  - Lane i outputs entries[spec_head + n_i], where n_i = number of set alloc_valid bits in lanes below i (compaction).
  - Outputs of invalid lanes are don't-care.
  - When alloc_valid!=0, alloc_ready=1 and flush=0: spec_head += popcount(alloc_valid) at the clock edge.
  - alloc_valid!=0 while alloc_ready=0 is ignored and the state is unchanged.
- Free:
  - Valid lanes are compacted in lane order and written to entries[tail + m_j], where m_j = number of set free_valid bits in lanes below j.
  - tail += popcount(free_valid).
  - Frees are accepted unconditionally, including in flush cycles.
  - Freed pregs become allocatable the next cycle.
- Commit: commit_head += popcount(commit_valid); lane positions are irrelevant.
- Flush: spec_head <= commit_head + popcount(commit_valid of the same cycle); allocations that cycle are dropped.
- free_count next = tail_next - spec_head_next, with alloc, free, commit and flush combined in one cycle.
- Wrap-around: index = pointer[low bits]; the wrap bit toggles when a pointer crosses DEPTH.
- Illegal conditions, flagged by simulation assertions and not handled in RTL:
  - a free that would overflow (count + frees > DEPTH);
  - commit_head advancing past spec_head;
  - freeing preg 0.

Decomposition:
- Shared package (parameters/typedefs): preg_t, the free-list pointer type, and the constants NUM_ARCH_REGS, NUM_PHYS_REGS, FL_DEPTH.
- One sub-module, lane_compactor #(WIDTH):
  - produces per-lane exclusive prefix counts and a total popcount from a valid vector;
  - instantiated three times: alloc, free, commit.

Test Plan:
- Reset, then alloc_valid=4'b1111 for 1 cycle -> alloc_preg = {32,33,34,35}; next cycle free_count=28 and alloc_preg lane0=36.
- Sparse alloc_valid=4'b1010 from reset -> lane1=32, lane3=33; spec_head +2; free_count=30.
- Allocate 28 (7 cycles of 4'b1111) -> free_count=4, alloc_ready=1. Allocate 1 more -> free_count=3, alloc_ready=0. A further alloc request is ignored; then free_valid=4'b0001 with free_preg=5 -> next cycle count=4, alloc_ready=1.
- Allocate 8 ({32..39}); commit_valid=4'b0011 together with flush=1 -> spec_head=2; next alloc lane0=34; free_count=30.
- Wrap: after 32 allocations, free {40,41,42,43}, then allocate 4 -> lanes receive 40..43 from entries[0..3] (tail wrapped), wrap bits correct, count=0.
- Same-cycle alloc 4'b1111 + free 4'b1111 + commit 4'b1111 at count=4 -> count stays 4; alloc_ready stays 1; the freed pregs appear on alloc_preg the next cycle.
